// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives launch and flush; the unit returns busy, done and HI/LO.
interface mdu_ctrl_if;
   logic        start;
   logic [2:0]  mdop;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, mdop, A, B, cancel, input busy, done, HI, LO);
   modport slave  (input start, mdop, A, B, cancel, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/multu/div/divu unit owning HI/LO. Latency is MULT_CYCLES or DIV_CYCLES busy cycles plus a done pulse.
// No backpressure: start is dropped while busy, and the hazard unit stalls on busy.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  bus
);

   localparam logic [3:0] MUL_LAST = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic        r_sgn, r_busy, r_done;

   logic        w_issue, w_launch, w_wr_hi, w_wr_lo, w_commit, w_wr_res, w_busy_nxt;
   logic [31:0] w_res_hi, w_res_lo;

   logic signed [32:0] w_ma, w_mb;
   logic signed [65:0] w_prod;
   logic        w_neg_a, w_neg_b;
   logic [31:0] w_mag_a, w_mag_b, w_div_b, w_uq, w_ur, w_q, w_r;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.cancel) begin
               if (bus.mdop == 3'd0 || bus.mdop == 3'd1) begin
                  w_state_nxt = MUL;
                  w_cnt_nxt   = MUL_LAST;
               end else if (bus.mdop == 3'd2 || bus.mdop == 3'd3) begin
                  w_state_nxt = DIV;
                  w_cnt_nxt   = DIV_LAST;
               end
            end
         end
         MUL, DIV: begin
            if (bus.cancel || r_cnt == 4'd0) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output / datapath-control logic
   always_comb begin
      w_issue    = (r_state == IDLE) && bus.start && !bus.cancel;
      w_launch   = w_issue && !bus.mdop[2];
      w_wr_hi    = w_issue && (bus.mdop == 3'd4);
      w_wr_lo    = w_issue && (bus.mdop == 3'd5);
      w_commit   = (r_state != IDLE) && (r_cnt == 4'd0) && !bus.cancel;
      // A zero divisor still completes but leaves HI/LO alone.
      w_wr_res   = w_commit && ((r_state == MUL) || (r_b != 32'd0));
      w_busy_nxt = (w_state_nxt != IDLE);
      w_res_hi   = (r_state == MUL) ? w_prod[63:32] : w_r;
      w_res_lo   = (r_state == MUL) ? w_prod[31:0]  : w_q;
   end

   // Functional mult/div on latched operands; the busy period covers their settling.
   always_comb begin
      w_ma    = {r_sgn & r_a[31], r_a};
      w_mb    = {r_sgn & r_b[31], r_b};
      w_prod  = 66'(w_ma) * 66'(w_mb);
      w_neg_a = r_sgn & r_a[31];
      w_neg_b = r_sgn & r_b[31];
      w_mag_a = w_neg_a ? -r_a : r_a;
      w_mag_b = w_neg_b ? -r_b : r_b;
      w_div_b = (r_b == 32'd0) ? 32'd1 : w_mag_b;
      w_uq    = w_mag_a / w_div_b;
      w_ur    = w_mag_a % w_div_b;
      w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
      w_r     = w_neg_a ? -w_ur : w_ur;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_sgn  <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_commit;
         if (w_launch) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_sgn <= ~bus.mdop[0];
         end
         if (w_wr_hi) r_hi <= bus.A;
         if (w_wr_lo) r_lo <= bus.A;
         if (w_wr_res) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus random checks of mdu_ctrl against an arithmetic reference of HI/LO and busy/done timing.
module tb_mdu_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu_ctrl_if bus();
   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
         3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle (chain=1) or one cycle later.
   task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input int inj_at, input bit chain);
      int n;
      bit cx;
      n  = (op < 3'd2) ? MC : DC;
      cx = 1'b0;
      bus.start = 1'b1; bus.mdop = op; bus.A = a; bus.B = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.cancel = 1'b0;
         check($sformatf("busy op%0d c%0d", op, k), {31'd0, bus.busy}, {31'd0, !cx});
         check($sformatf("done op%0d c%0d", op, k), {31'd0, bus.done}, 32'd0);
         if (k == cancel_at) begin bus.cancel = 1'b1; cx = 1'b1; end
         if (k == inj_at) begin bus.start = 1'b1; bus.mdop = 3'd5; bus.A = 32'hDEAD; end
      end
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      if (!cx) model(op, a, b);
      check($sformatf("busy_end op%0d", op), {31'd0, bus.busy}, 32'd0);
      check($sformatf("done_end op%0d", op), {31'd0, bus.done}, {31'd0, !cx});
      check($sformatf("HI op%0d", op), bus.HI, m_hi);
      check($sformatf("LO op%0d", op), bus.LO, m_lo);
      if (!chain) begin
         @(negedge clk);
         check($sformatf("done_once op%0d", op), {31'd0, bus.done}, 32'd0);
      end
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] a, input bit cncl);
      bus.start = 1'b1; bus.mdop = op; bus.A = a; bus.cancel = cncl;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      if (!cncl) model(op, a, 32'd0);
      @(negedge clk);
      check("mt HI", bus.HI, m_hi);
      check("mt LO", bus.LO, m_lo);
      check("mt busy", {31'd0, bus.busy}, 32'd0);
      check("mt done", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      reset = 1'b1;
      bus.start = 1'b0; bus.mdop = '0; bus.A = '0; bus.B = '0; bus.cancel = 1'b0;
      repeat (2) @(negedge clk);
      check("rst busy", {31'd0, bus.busy}, 32'd0);
      check("rst done", {31'd0, bus.done}, 32'd0);
      check("rst HI", bus.HI, 32'd0);
      check("rst LO", bus.LO, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      md_op(3'd0, 32'hFFFFFFFF, 32'h2, 0, 0, 0);
      check("mult HI", bus.HI, 32'hFFFFFFFF);
      check("mult LO", bus.LO, 32'hFFFFFFFE);
      md_op(3'd1, 32'hFFFFFFFF, 32'h2, 0, 0, 0);
      check("multu HI", bus.HI, 32'h1);
      check("multu LO", bus.LO, 32'hFFFFFFFE);
      md_op(3'd2, 32'hFFFFFFF9, 32'h2, 0, 0, 0);
      check("div HI", bus.HI, 32'hFFFFFFFF);
      check("div LO", bus.LO, 32'hFFFFFFFD);
      md_op(3'd3, 32'd7, 32'd2, 0, 0, 0);
      check("divu HI", bus.HI, 32'd1);
      check("divu LO", bus.LO, 32'd3);
      md_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
      check("divovf HI", bus.HI, 32'd0);
      check("divovf LO", bus.LO, 32'h80000000);

      mt(3'd4, 32'h11, 1'b0);
      mt(3'd5, 32'h22, 1'b0);
      md_op(3'd3, 32'd5, 32'd0, 0, 0, 0);
      check("div0 HI", bus.HI, 32'h11);
      check("div0 LO", bus.LO, 32'h22);

      mt(3'd4, 32'd0, 1'b0);
      mt(3'd5, 32'd0, 1'b0);
      md_op(3'd1, 32'd3, 32'd4, 0, 2, 1);
      check("inj HI", bus.HI, 32'd0);
      check("inj LO", bus.LO, 32'hC);
      md_op(3'd0, 32'd7, 32'd6, 0, 0, 0);
      check("b2b LO", bus.LO, 32'd42);

      mt(3'd4, 32'h99, 1'b1);
      md_op(3'd2, 32'd100, 32'd7, 3, 0, 0);
      md_op(3'd2, 32'd100, 32'd7, DC, 0, 0);
      check("cancel_last LO", bus.LO, 32'd42);

      mt(3'd4, 32'h5A5A, 1'b0);
      bus.start = 1'b1; bus.mdop = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      m_hi = '0; m_lo = '0;
      check("midrst busy", {31'd0, bus.busy}, 32'd0);
      check("midrst done", {31'd0, bus.done}, 32'd0);
      check("midrst HI", bus.HI, m_hi);
      check("midrst LO", bus.LO, m_lo);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      md_op(3'd3, 32'd100, 32'd7, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 5));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 9);
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         if (op < 3'd4) md_op(op, a, b, 0, 0, 1'($urandom_range(0, 1)));
         else           mt(op, a, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit with its own sequencing controller. It sits beside the ALU in the EX stage and executes mult/multu/div/divu over a fixed number of cycles. It owns the HI/LO registers and handles mthi/mtlo writes. It reports busy so the hazard unit can stall mfhi/mflo and further MD instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request to launch the operation given by mdop
mdop  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved
A  input  32  rs operand (dividend, multiplicand, or mthi/mtlo data)
B  input  32  rt operand (divisor, multiplier)
cancel  input  1  exception flush; aborts any in-flight operation
busy  output  1  registered; high while a mult/div is in flight
done  output  1  registered one-cycle pulse; HI/LO were just committed
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, counter=0, busy=0, done=0, HI=0, LO=0.
- State machine: IDLE, MUL, DIV. A 4-bit down-counter tracks the remaining busy cycles.
- IDLE with start=1 and cancel=0, sampled at edge t0:
  - mdop 0/1: latch A, B and the signed flag; go to MUL; counter=MULT_CYCLES-1.
  - mdop 2/3: latch A, B and the signed flag; go to DIV; counter=DIV_CYCLES-1.
  - mdop 4: HI<=A at t0. mdop 5: LO<=A at t0. No busy, no done.
  - mdop 6/7: no effect.
- Busy timing: busy=1 in cycles t0+1 through t0+N, where N is the op latency.
- Each edge in MUL/DIV with counter≠0 decrements the counter.
- At the edge with counter=0 (end of cycle t0+N):
  - HI/LO are written.
  - State returns to IDLE.
  - busy=0 and done=1 in cycle t0+N+1.
- done is high for exactly one cycle. It pulses only for mult/div completion, never for mthi/mtlo.
- A new start may be accepted in the same cycle that done=1, since the block is IDLE then.
- Results are computed from the latched operands only. Changes on A/B after t0 have no effect.
- mult: {HI,LO} = signed 64-bit product. multu: {HI,LO} = unsigned 64-bit product.
- div (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- divu (unsigned): LO = A/B, HI = A%B.
- Divide by zero (div or divu with B=0): HI and LO stay unchanged. The full DIV_CYCLES busy period still runs and done still pulses.
- start while busy=1: ignored entirely. No operand latch, no mthi/mtlo write. The pipeline must stall before issuing.
- cancel=1 while busy:
  - State goes to IDLE at the next edge; busy=0 after that edge.
  - HI/LO are not written and done stays 0.
  - cancel on the final busy cycle also suppresses the commit.
- cancel=1 together with start in IDLE: cancel wins and start is ignored, including mthi/mtlo.
- Reset mid-operation: outputs go to their reset values immediately and the in-flight result is discarded.

Test Plan:
- mult A=0xFFFFFFFF, B=0x00000002 -> busy high 5 cycles, then done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x11 then mtlo A=0x22 (busy stays 0, no done) -> HI=0x11, LO=0x22. Then divu B=0 -> busy 10 cycles, done pulses, HI=0x11, LO=0x22 unchanged.
- multu 3×4 started, then start with mdop=5, A=0xDEAD on busy cycle 2 -> mtlo ignored; final HI=0, LO=0x0000000C. New start on the done cycle is accepted.
- div 100/7 started, cancel on busy cycle 3 -> busy=0 next cycle, done never pulses, HI/LO keep their prior values. Repeat with cancel on the last busy cycle -> same result.
- reset asserted mid-divide between edges -> busy, done, HI and LO read 0 before the next clk edge. After release, block is IDLE and accepts start.
